// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, N data bits LSB first,
// optional even-parity bit, stop bit, each held for CLKS_PER_BIT clocks.
module serial_tx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         tx_serial,
  output logic         tx_busy,
  output logic         tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic [N-1:0]  shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic          ready_reg;
  logic          done_reg;
  logic          tx_line;
  logic          accept;
  logic          bit_end;
  logic          last_bit;

  assign accept   = load_valid && ready_reg && (state_reg == IDLE);
  assign bit_end  = (cnt_reg == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_reg == BW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      ready_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      // ready stays low for the first edge out of reset, then tracks IDLE
      ready_reg  <= (state_next == IDLE);
      done_reg   <= (state_reg == STOP) && bit_end;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_line     = 1'b1;

    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (accept) begin
          shift_next  = data_in;
          parity_next = ^data_in;
          state_next  = START;
        end
      end
      START: begin
        tx_line = 1'b0;
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        // the latched word is consumed from bit 0 upward
        tx_line = shift_reg[0];
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          bit_next   = bit_reg + 1'b1;
          if (last_bit) begin
            bit_next = '0;
            if (PARITY_EN) begin
              state_next = PARITY;
            end else begin
              state_next = STOP;
            end
          end
        end
      end
      PARITY: begin
        tx_line = parity_reg;
        if (bit_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        tx_line = 1'b1;
        if (bit_end) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx_serial  = tx_line;
  assign tx_busy    = (state_reg != IDLE);
  assign load_ready = ready_reg;
  assign tx_done    = done_reg;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboarded bench for serial_tx: three instances (8/4/no parity, 8/4/parity, 1/1/no parity);
// expected line waveforms are queued at stimulus time and checked when tx_done appears.
module tb_serial_tx;

  typedef struct {
    int          dut;
    int          len;
    logic [63:0] bits;
    string       name;
  } frame_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] lv;
  logic [7:0] din [3];
  logic [2:0] rdy, tx, busy, done;

  int vectors = 0;
  int miscompares = 0;
  frame_t exp_q[$];
  frame_t e;
  logic [63:0] cap [3];
  int clen [3];
  int n;

  always #5 clk = ~clk;

  serial_tx #(.N(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u0 (
    .clk(clk), .reset(rst_n[0]), .data_in(din[0]), .load_valid(lv[0]),
    .load_ready(rdy[0]), .tx_serial(tx[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );
  serial_tx #(.N(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u1 (
    .clk(clk), .reset(rst_n[1]), .data_in(din[1]), .load_valid(lv[1]),
    .load_ready(rdy[1]), .tx_serial(tx[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );
  serial_tx #(.N(1), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u2 (
    .clk(clk), .reset(rst_n[2]), .data_in(din[2][0:0]), .load_valid(lv[2]),
    .load_ready(rdy[2]), .tx_serial(tx[2]), .tx_busy(busy[2]), .tx_done(done[2])
  );

  // Monitor: records the line during every busy cycle, compares on tx_done
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k]) begin
        clen[k] = 0;
        cap[k]  = '0;
      end else begin
        if (done[k]) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL frame dut%0d: got unexpected tx_done, required none", k);
          end else begin
            e = exp_q.pop_front();
            if (e.dut != k || e.len != clen[k] || e.bits != cap[k]) begin
              miscompares++;
              $display("FAIL frame %s dut%0d: got len %0d bits %h, required dut%0d len %0d bits %h",
                       e.name, k, clen[k], cap[k], e.dut, e.len, e.bits);
            end else begin
              $display("frame %s dut%0d: len %0d bits %h ok", e.name, k, clen[k], cap[k]);
            end
          end
          vectors++;
          if (tx[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_line dut%0d: got %b, required 1", k, tx[k]);
          end
          clen[k] = 0;
          cap[k]  = '0;
        end
        if (busy[k] && clen[k] < 64) begin
          cap[k][clen[k]] = tx[k];
          clen[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // pat is the hand-written line level per bit period; each char is held cpb cycles
  task automatic expect_frame(input int k, input string pat, input string name);
    frame_t f;
    int cpb;
    cpb    = (k == 2) ? 1 : 4;
    f.dut  = k;
    f.len  = 0;
    f.bits = '0;
    f.name = name;
    for (int i = 0; i < pat.len(); i++) begin
      for (int c = 0; c < cpb; c++) begin
        f.bits[f.len] = (pat.getc(i) == 8'd49);
        f.len++;
      end
    end
    exp_q.push_back(f);
  endtask

  task automatic release_and_load(input int k, input logic [7:0] d, input string pat, input string name);
    rst_n[k] = 1'b1;
    din[k]   = d;
    lv[k]    = 1'b1;
    tick();
    check("ready_first_edge", rdy[k], 1);
    check("idle_first_edge", busy[k], 0);
    expect_frame(k, pat, name);
    tick();
    check("busy_after_accept", busy[k], 1);
    check("ready_low_in_frame", rdy[k], 0);
    lv[k]  = 1'b0;
    din[k] = ~d;
  endtask

  task automatic load(input int k, input logic [7:0] d, input string pat, input string name);
    expect_frame(k, pat, name);
    din[k] = d;
    lv[k]  = 1'b1;
    tick();
    check("busy_after_load", busy[k], 1);
    lv[k]  = 1'b0;
    din[k] = ~d;
  endtask

  task automatic wait_idle(input int k, output int cycles);
    cycles = 0;
    while (!rdy[k] && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic end_of_frame(input int k);
    check("done_at_idle", done[k], 1);
    check("line_at_idle", tx[k], 1);
    tick();
    check("done_one_cycle", done[k], 0);
  endtask

  initial begin
    rst_n = 3'b000;
    lv    = 3'b000;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    #1;
    check("reset_tx", tx, 3'b111);
    check("reset_ready", rdy, 3'b000);
    check("reset_busy", busy, 3'b000);
    check("reset_done", done, 3'b000);
    repeat (2) tick();
    check("reset_ready_clocked", rdy, 3'b000);

    // 0xA5, single pulse
    release_and_load(0, 8'hA5, "0101001011", "u0_A5");
    wait_idle(0, n);
    check("u0_A5_cycles", n, 40);
    end_of_frame(0);

    // back-to-back with load_valid held: 0x01 then 0xFF
    expect_frame(0, "0100000001", "u0_01");
    din[0] = 8'h01;
    lv[0]  = 1'b1;
    tick();
    check("b2b_first_busy", busy[0], 1);
    din[0] = 8'hFF;
    expect_frame(0, "0111111111", "u0_FF");
    wait_idle(0, n);
    check("b2b_first_cycles", n, 40);
    check("b2b_gap_done", done[0], 1);
    check("b2b_gap_line", tx[0], 1);
    tick();
    check("b2b_second_busy", busy[0], 1);
    lv[0]  = 1'b0;
    din[0] = 8'h00;
    wait_idle(0, n);
    check("b2b_second_cycles", n, 40);
    end_of_frame(0);

    // offer 0x3C at cycle 10 of a frame in progress
    load(0, 8'hA5, "0101001011", "u0_A5_ignore");
    repeat (10) tick();
    din[0] = 8'h3C;
    lv[0]  = 1'b1;
    check("ignore_ready_low", rdy[0], 0);
    tick();
    lv[0] = 1'b0;
    check("ignore_still_busy", busy[0], 1);
    wait_idle(0, n);
    check("ignore_remaining_cycles", n, 29);
    end_of_frame(0);

    // abort during data bit 3, nothing queued for this frame
    din[0] = 8'hA5;
    lv[0]  = 1'b1;
    tick();
    lv[0] = 1'b0;
    repeat (17) tick();
    check("pre_abort_bit3", tx[0], 0);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("abort_tx", tx[0], 1);
    check("abort_busy", busy[0], 0);
    check("abort_ready", rdy[0], 0);
    check("abort_done", done[0], 0);
    repeat (3) tick();
    release_and_load(0, 8'h5A, "0010110101", "u0_5A_after_abort");
    wait_idle(0, n);
    check("after_abort_cycles", n, 40);
    end_of_frame(0);

    // parity instance: 0xA5 (parity 0), 0x01 (parity 1)
    release_and_load(1, 8'hA5, "01010010101", "u1_A5_par");
    wait_idle(1, n);
    check("u1_A5_cycles", n, 44);
    end_of_frame(1);
    load(1, 8'h01, "01000000011", "u1_01_par");
    wait_idle(1, n);
    check("u1_01_cycles", n, 44);
    end_of_frame(1);

    // N=1, one clock per bit
    release_and_load(2, 8'h01, "011", "u2_1");
    wait_idle(2, n);
    check("u2_1_cycles", n, 3);
    end_of_frame(2);
    load(2, 8'h00, "001", "u2_0");
    wait_idle(2, n);
    check("u2_0_cycles", n, 3);
    end_of_frame(2);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1000000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
